// File: rtl/ram_bist.sv
// ============================================================================
//  Module   : ram_bist
//  Purpose  : March-style self-test engine driving both ports of a dual-port
//             RAM: write P(a), read back, then repeat with ~P(a).
//  Option   : RAM_BIST_STOP_ON_FAIL_EN - abort to FIN on the first miscompare
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bist #(
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 5,
    parameter int A_MAX    = 32,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [D_WIDTH-1:0] seed,
    output logic [A_WIDTH-1:0] address_write,
    output logic [D_WIDTH-1:0] data_write,
    output logic               write_enable,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [D_WIDTH-1:0] fail_exp,
    output logic [D_WIDTH-1:0] fail_got,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_DR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RD1  = 3'd5,
        S_DR1  = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    localparam logic [A_WIDTH-1:0] C_A_LAST  = A_WIDTH'(A_MAX - 1);
    localparam int                 C_DR_W    = $clog2(READ_LAT + 2);
    localparam logic [C_DR_W-1:0]  C_DR_LAST = C_DR_W'(READ_LAT);

    state_t                            state_q, state_d;
    logic [A_WIDTH-1:0]                cnt_q, cnt_d;
    logic [C_DR_W-1:0]                 drain_q, drain_d;
    logic [D_WIDTH-1:0]                seed_q, seed_d;
    logic                              write_enable_q, write_enable_d;
    logic [A_WIDTH-1:0]                address_write_q, address_write_d;
    logic [D_WIDTH-1:0]                data_write_q, data_write_d;
    logic [A_WIDTH-1:0]                address_read_q, address_read_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              pass_q, pass_d;
    logic [A_WIDTH-1:0]                fail_addr_q, fail_addr_d;
    logic [D_WIDTH-1:0]                fail_exp_q, fail_exp_d;
    logic [D_WIDTH-1:0]                fail_got_q, fail_got_d;
    logic [7:0]                        err_count_q, err_count_d;

    // Compare pipeline: stage 0 is loaded with the read address, stage
    // READ_LAT lines up with the returning data_read.
    logic [READ_LAT:0]                 pv_q, pv_d;
    logic [READ_LAT:0][A_WIDTH-1:0]    pa_q, pa_d;
    logic [READ_LAT:0][D_WIDTH-1:0]    pe_q, pe_d;

    logic                              w_miscmp;
    logic                              w_inv;
    logic [D_WIDTH-1:0]                w_pat;

    function automatic logic [D_WIDTH-1:0] f_pattern(
        input logic [A_WIDTH-1:0] a,
        input logic [D_WIDTH-1:0] s,
        input logic               inv
    );
        logic [D_WIDTH-1:0] p;
        p = D_WIDTH'(a) ^ s;
        return inv ? ~p : p;
    endfunction

    assign w_miscmp = pv_q[READ_LAT] && (data_read != pe_q[READ_LAT]);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        drain_d         = drain_q;
        seed_d          = seed_q;
        write_enable_d  = 1'b0;
        address_write_d = address_write_q;
        data_write_d    = data_write_q;
        address_read_d  = address_read_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        pass_d          = pass_q;
        fail_addr_d     = fail_addr_q;
        fail_exp_d      = fail_exp_q;
        fail_got_d      = fail_got_q;
        err_count_d     = err_count_q;
        pv_d            = pv_q << 1;
        pa_d            = pa_q << A_WIDTH;
        pe_d            = pe_q << D_WIDTH;
        w_inv           = 1'b0;
        w_pat           = '0;

        if (w_miscmp) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (err_count_q == 8'd0) begin
                fail_addr_d = pa_q[READ_LAT];
                fail_exp_d  = pe_q[READ_LAT];
                fail_got_d  = data_read;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR0;
                    cnt_d       = '0;
                    seed_d      = seed;
                    err_count_d = 8'd0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    pass_d      = 1'b0;
                end
            end
            S_WR0, S_WR1: begin
                if (cnt_q == C_A_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            S_RD0, S_RD1: begin
                if (cnt_q == C_A_LAST) begin
                    cnt_d   = '0;
                    drain_d = '0;
                    state_d = (state_q == S_RD0) ? S_DR0 : S_DR1;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            S_DR0, S_DR1: begin
                if (drain_q == C_DR_LAST) begin
                    state_d = (state_q == S_DR0) ? S_WR1 : S_FIN;
                end else begin
                    drain_d = drain_q + C_DR_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef RAM_BIST_STOP_ON_FAIL_EN
        if (w_miscmp && busy_q) begin
            state_d = S_FIN;
            pv_d    = '0;
        end
`endif

        // Registered outputs are derived from the state being entered, so
        // they are valid during the cycle that state occupies.
        w_inv = (state_d == S_WR1) || (state_d == S_RD1);
        w_pat = f_pattern(cnt_d, seed_d, w_inv);

        if ((state_d == S_WR0) || (state_d == S_WR1)) begin
            write_enable_d  = 1'b1;
            address_write_d = cnt_d;
            data_write_d    = w_pat;
        end

        if ((state_d == S_RD0) || (state_d == S_RD1)) begin
            address_read_d = cnt_d;
            pv_d[0]        = 1'b1;
            pa_d[0]        = cnt_d;
            pe_d[0]        = w_pat;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);

        if (state_d == S_FIN) begin
            done_d = 1'b1;
            pass_d = (err_count_d == 8'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            drain_q         <= '0;
            seed_q          <= '0;
            write_enable_q  <= 1'b0;
            address_write_q <= '0;
            data_write_q    <= '0;
            address_read_q  <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_addr_q     <= '0;
            fail_exp_q      <= '0;
            fail_got_q      <= '0;
            err_count_q     <= 8'd0;
            pv_q            <= '0;
            pa_q            <= '0;
            pe_q            <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            drain_q         <= drain_d;
            seed_q          <= seed_d;
            write_enable_q  <= write_enable_d;
            address_write_q <= address_write_d;
            data_write_q    <= data_write_d;
            address_read_q  <= address_read_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            fail_addr_q     <= fail_addr_d;
            fail_exp_q      <= fail_exp_d;
            fail_got_q      <= fail_got_d;
            err_count_q     <= err_count_d;
            pv_q            <= pv_d;
            pa_q            <= pa_d;
            pe_q            <= pe_d;
        end
    end

    assign address_write = address_write_q;
    assign data_write    = data_write_q;
    assign write_enable  = write_enable_q;
    assign address_read  = address_read_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_exp      = fail_exp_q;
    assign fail_got      = fail_got_q;
    assign err_count     = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist.sv
// ============================================================================
//  Module   : tb_ram_bist
//  Purpose  : Directed self-checking bench for ram_bist with a behavioural
//             dual-port RAM that can inject stuck-bit and all-zero faults.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bist;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [4:0] address_write;
    logic [7:0] data_write;
    logic       write_enable;
    logic [4:0] address_read;
    logic [7:0] data_read;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_addr;
    logic [7:0] fail_exp;
    logic [7:0] fail_got;
    logic [7:0] err_count;

    // Larger instance (A_MAX below 2^A_WIDTH) reading a RAM that returns 0.
    logic       s_start;
    logic [7:0] s_seed;
    logic [7:0] s_address_write;
    logic [7:0] s_data_write;
    logic       s_write_enable;
    logic [7:0] s_address_read;
    logic [7:0] s_data_read;
    logic       s_busy;
    logic       s_done;
    logic       s_pass;
    logic [7:0] s_fail_addr;
    logic [7:0] s_fail_exp;
    logic [7:0] s_fail_got;
    logic [7:0] s_err_count;

    int checks = 0;
    int errors = 0;

    ram_bist #(.D_WIDTH(8), .A_WIDTH(5), .A_MAX(32), .READ_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .address_write(address_write), .data_write(data_write),
        .write_enable(write_enable), .address_read(address_read),
        .data_read(data_read), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
        .err_count(err_count)
    );

    ram_bist #(.D_WIDTH(8), .A_WIDTH(8), .A_MAX(200), .READ_LAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .seed(s_seed),
        .address_write(s_address_write), .data_write(s_data_write),
        .write_enable(s_write_enable), .address_read(s_address_read),
        .data_read(s_data_read), .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_addr(s_fail_addr), .fail_exp(s_fail_exp), .fail_got(s_fail_got),
        .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign s_data_read = 8'h00;

    logic [7:0] mem [0:31];
    bit         stuck_en = 1'b0;
    bit         zero_en  = 1'b0;

    always @(posedge clk) begin
        if (write_enable) mem[address_write] <= data_write;
        if (zero_en)
            data_read <= 8'h00;
        else if (stuck_en && address_read == 5'h1B)
            data_read <= mem[address_read] | 8'h01;
        else
            data_read <= mem[address_read];
    end

    task automatic run_test(
        input  logic [7:0]  s,
        input  logic [7:0]  s_after,
        input  int          restart_at,
        input  bit          fin_start,
        output int          busy_cyc,
        output bit          done_seen,
        output bit          done_next,
        output bit          busy_after,
        output int          n1b,
        output logic [7:0]  w1b_a,
        output logic [7:0]  w1b_b,
        output logic [29:0] snap
    );
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed  = s_after;
        snap  = {pass, err_count, fail_addr, fail_exp, fail_got};
        busy_cyc = 0; done_seen = 1'b0; n1b = 0; w1b_a = 8'h00; w1b_b = 8'h00;
        for (int i = 1; i <= 2000; i++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            if (write_enable && address_write == 5'h1B) begin
                if (n1b == 0) w1b_a = data_write;
                else          w1b_b = data_write;
                n1b++;
            end
            start = (i == restart_at);
            @(negedge clk);
        end
        start = fin_start && done_seen;
        @(negedge clk);
        start      = 1'b0;
        done_next  = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, write_enable, address_write, data_write, address_read,
             fail_addr, fail_exp, fail_got, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b we=%b err=%0d aw=%h ar=%h",
                     busy, done, pass, write_enable, err_count, address_write, address_read);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b we=%b, expected 0 0", busy, write_enable);
        end
    endtask

    task automatic test_pass_run();
        int busy_cyc, n1b; bit dseen, dnext, bafter; logic [7:0] wa, wb; logic [29:0] snap;
        run_test(8'hA5, 8'h00, 0, 1'b0, busy_cyc, dseen, dnext, bafter, n1b, wa, wb, snap);
        checks++;
        if (dseen !== 1'b1) begin errors++; $display("FAIL pass_done_seen: got %b expected 1", dseen); end
        checks++;
        if (busy_cyc != 132) begin errors++; $display("FAIL pass_busy_cycles: got %0d expected 132", busy_cyc); end
        checks++;
        if (dnext !== 1'b0) begin errors++; $display("FAIL pass_done_width: done=%b next cycle, expected 0", dnext); end
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            errors++; $display("FAIL pass_result: pass=%b err=%0d expected 1 0", pass, err_count);
        end
        checks++;
        if (n1b != 2 || wa !== 8'hBE || wb !== 8'h41) begin
            errors++; $display("FAIL pass_write_1b: n=%0d data=%h,%h expected 2 BE,41", n1b, wa, wb);
        end
    endtask

    task automatic test_fault();
        int busy_cyc, n1b; bit dseen, dnext, bafter; logic [7:0] wa, wb; logic [29:0] snap;
        stuck_en = 1'b1;
        run_test(8'hA5, 8'hA5, 0, 1'b0, busy_cyc, dseen, dnext, bafter, n1b, wa, wb, snap);
        checks++;
        if (busy_cyc != (STOP ? 61 : 132) || dseen !== 1'b1) begin
            errors++; $display("FAIL fault_busy_cycles: got %0d done=%b expected %0d 1",
                               busy_cyc, dseen, STOP ? 61 : 132);
        end
        checks++;
        if (pass !== 1'b0 || err_count !== 8'd1) begin
            errors++; $display("FAIL fault_result: pass=%b err=%0d expected 0 1", pass, err_count);
        end
        checks++;
        if (fail_addr !== 5'h1B || fail_exp !== 8'hBE || fail_got !== 8'hBF) begin
            errors++; $display("FAIL fault_capture: addr=%h exp=%h got=%h expected 1B BE BF",
                               fail_addr, fail_exp, fail_got);
        end
        checks++;
        if (n1b != (STOP ? 1 : 2)) begin
            errors++; $display("FAIL fault_write_count: got %0d expected %0d", n1b, STOP ? 1 : 2);
        end
    endtask

    task automatic test_back_to_back();
        int busy_cyc, n1b; bit dseen, dnext, bafter; logic [7:0] wa, wb; logic [29:0] snap;
        stuck_en = 1'b0;
        run_test(8'hA5, 8'hA5, 40, 1'b1, busy_cyc, dseen, dnext, bafter, n1b, wa, wb, snap);
        checks++;
        if (snap !== 30'd0) begin
            errors++; $display("FAIL rerun_clear: status after start %h expected 0", snap);
        end
        checks++;
        if (busy_cyc != 132 || dseen !== 1'b1) begin
            errors++; $display("FAIL restart_ignored: busy=%0d done=%b expected 132 1", busy_cyc, dseen);
        end
        checks++;
        if (bafter !== 1'b0) begin
            errors++; $display("FAIL start_in_fin: busy=%b after start during FIN, expected 0", bafter);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            errors++; $display("FAIL rerun_result: busy=%b pass=%b expected 0 1", busy, pass);
        end
    endtask

    task automatic test_reset_mid();
        seed  = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || busy !== 1'b1 || data_write !== ~(address_write ^ 8'hA5)) begin
            errors++; $display("FAIL mid_wr1_active: we=%b busy=%b aw=%h dw=%h", write_enable, busy,
                               address_write, data_write);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_abort: we=%b busy=%b expected 0 0", write_enable, busy);
        end
        checks++;
        if ({done, pass, address_write, data_write, address_read, fail_addr, fail_exp, fail_got,
             err_count} !== '0) begin
            errors++; $display("FAIL async_status_clear: aw=%h dw=%h ar=%h err=%0d expected all 0",
                               address_write, data_write, address_read, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write_enable !== 1'b0) begin
            errors++; $display("FAIL no_autostart: busy=%b we=%b expected 0 0", busy, write_enable);
        end
    endtask

    task automatic test_zero_ram();
        int busy_cyc, n1b; bit dseen, dnext, bafter; logic [7:0] wa, wb; logic [29:0] snap;
        zero_en = 1'b1;
        run_test(8'h00, 8'h00, 0, 1'b0, busy_cyc, dseen, dnext, bafter, n1b, wa, wb, snap);
        zero_en = 1'b0;
        checks++;
        if (dseen !== 1'b1 || pass !== 1'b0 || err_count !== (STOP ? 8'd1 : 8'd63)) begin
            errors++; $display("FAIL zero_count: done=%b pass=%b err=%0d expected 1 0 %0d",
                               dseen, pass, err_count, STOP ? 1 : 63);
        end
        checks++;
        if (fail_addr !== 5'h01 || fail_exp !== 8'h01 || fail_got !== 8'h00) begin
            errors++; $display("FAIL zero_capture: addr=%h exp=%h got=%h expected 01 01 00",
                               fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_saturation();
        int  busy_cyc = 0;
        int  max_aw = 0;
        int  max_ar = 0;
        bit  wrapped = 1'b0;
        bit  dseen = 1'b0;
        bit  prev_busy = 1'b0;
        int  prev_err = 0;
        s_seed  = 8'h00;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (s_done) begin
                dseen = 1'b1;
                break;
            end
            if (s_busy) begin
                busy_cyc++;
                if (int'(s_address_write) > max_aw) max_aw = int'(s_address_write);
                if (int'(s_address_read) > max_ar) max_ar = int'(s_address_read);
                if (prev_busy && int'(s_err_count) < prev_err) wrapped = 1'b1;
            end
            prev_busy = s_busy;
            prev_err  = int'(s_err_count);
            @(negedge clk);
        end
        checks++;
        if (dseen !== 1'b1 || busy_cyc != (STOP ? 203 : 804)) begin
            errors++; $display("FAIL sat_busy_cycles: got %0d done=%b expected %0d 1",
                               busy_cyc, dseen, STOP ? 203 : 804);
        end
        checks++;
        if (s_err_count !== (STOP ? 8'd1 : 8'd255) || wrapped) begin
            errors++; $display("FAIL sat_err_count: got %0d wrapped=%b expected %0d 0",
                               s_err_count, wrapped, STOP ? 1 : 255);
        end
        checks++;
        if (max_aw != 199 || max_ar != (STOP ? 2 : 199)) begin
            errors++; $display("FAIL sat_addr_bound: max_aw=%0d max_ar=%0d expected 199 %0d",
                               max_aw, max_ar, STOP ? 2 : 199);
        end
        checks++;
        if (s_pass !== 1'b0 || s_fail_addr !== 8'h01 || s_fail_exp !== 8'h01 || s_fail_got !== 8'h00) begin
            errors++; $display("FAIL sat_capture: pass=%b addr=%h exp=%h got=%h expected 0 01 01 00",
                               s_pass, s_fail_addr, s_fail_exp, s_fail_got);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        seed    = 8'h00;
        s_start = 1'b0;
        s_seed  = 8'h00;
        test_reset();
        test_pass_run();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        test_zero_ram();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
